hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
Time-multiplexed driver for the 4-digit seven-segment display. It holds a 16-bit value and 4 decimal-point bits, and steps through the digits at a programmable refresh rate. Each step presents one nibble, the 2-bit digit index and the dot bit to the binary-to-hex segment decoder. It is the sequencing side of the decoder interface: it generates the decoder's BINARY, SEGMENT and DOT inputs.

Parameters:
REFRESH_DIV, 100000, CLK cycles per digit dwell (1 kHz per digit at 100 MHz); legal range >= 1
CNT_W, $clog2(REFRESH_DIV), prescaler counter width; derived, not overridden

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
VALUE_IN  in  16  value to display; digit k = VALUE_IN[4k+3:4k]
DOTS_IN  in  4  decimal points; bit k = dot of digit k
LOAD  in  1  capture VALUE_IN/DOTS_IN into the shadow register this cycle
LOAD_ACK  out  1  one-cycle pulse when the shadow register is committed to the displayed register
ENABLE  in  1  scan enable; low freezes the scan
BINARY  out  4  nibble of the current digit, to the decoder
SEGMENT  out  2  current digit index 0..3, to the decoder
DOT  out  1  dot bit of the current digit
FRAME_DONE  out  1  one-cycle pulse on the tick that wraps digit 3 to digit 0

Behaviour:
- One clock, CLK. RESET is synchronous and active-high.
- Reset values:
  - prescaler = 0, digit_idx = 0, active = 0, shadow = 0, pending = 0.
  - BINARY = 0, SEGMENT = 0, DOT = 0, LOAD_ACK = 0, FRAME_DONE = 0.
- Reset asserted mid-frame discards any pending load and produces no ACK.
- Prescaler:
  - Increments while ENABLE = 1.
  - At REFRESH_DIV-1 it raises tick and wraps to 0.
  - With REFRESH_DIV = 1, tick is asserted on every enabled cycle.
- ENABLE = 0 holds the prescaler, digit_idx and all outputs. Pulse outputs are 0 while disabled. LOAD is still accepted.
- Scan on tick: digit_idx <= digit_idx+1 mod 4. Outputs are registered and are loaded on the same edge from the new index:
  - SEGMENT <= next_idx
  - BINARY <= active[4*next_idx +: 4]
  - DOT <= active_dots[next_idx]
- Load handshake:
  - LOAD = 1 writes shadow <= {DOTS_IN, VALUE_IN} and sets pending = 1.
  - A later LOAD before commit overwrites shadow; only the last value is displayed and only one ACK is issued.
- Commit:
  - Happens on a tick with digit_idx = 3 and pending = 1: active <= shadow, pending cleared, LOAD_ACK = 1 for that cycle.
  - Digit 0 outputs on that edge come from the new shadow value (bypass), so the display never tears mid-frame.
- FRAME_DONE is 1 on every tick with digit_idx = 3, regardless of pending.
- LOAD on the commit cycle: the commit uses the pre-edge shadow. The new data is written to shadow and pending stays 1, so it commits one frame later with a second ACK.
- Latency:
  - Outputs change on the tick edge itself.
  - A load becomes visible on the first frame boundary after capture, at most 4*REFRESH_DIV cycles later.

Optional Feature:
HEX_SCAN_BLANK_EN:
- Defined: adds an output port BLANK (1 bit), registered alongside BINARY.
  - BLANK = 1 when the current digit is a leading zero: this nibble and all higher nibbles of active are 0, and SEGMENT != 0.
  - Digit 0 is never blanked. DOT is unaffected by BLANK. BLANK resets to 0.
- Undefined: the BLANK port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package hex_display_pkg:
  - NUM_DIGITS = 4, DIGIT_W = 4, IDX_W = 2, DEFAULT_REFRESH_DIV = 100000
  - typedef digit_idx_t (IDX_W bits), typedef disp_word_t (NUM_DIGITS*DIGIT_W bits)
- Sub-module refresh_tick_gen: parameterised prescaler with inputs CLK, RESET, ENABLE and a one-cycle TICK output. The scanner FSM, shadow/active registers and handshake stay in hex_display_scanner.

Test Plan:
- All scenarios use REFRESH_DIV = 4.
1. Reset, ENABLE = 1, no LOAD -> BINARY = 0, DOT = 0; SEGMENT steps 0,1,2,3,0 every 4 cycles; FRAME_DONE pulses every 16 cycles; LOAD_ACK never rises.
2. LOAD VALUE_IN = 0xA3C5, DOTS_IN = 4'b0100 while SEGMENT = 1 -> no output change until the wrap; LOAD_ACK coincides with FRAME_DONE; then BINARY = 5, C, 3, A for SEGMENT = 0..3, with DOT = 1 only at SEGMENT = 2.
3. LOAD 0x1111, then LOAD 0x2222 in the same frame -> one LOAD_ACK; display shows 2 on every digit, never 1.
4. LOAD 0x1234 mid-frame, then LOAD 0x5678 exactly on the commit cycle -> 0x1234 shown for one frame; a second LOAD_ACK 16 cycles after the first; 0x5678 shown thereafter.
5. ENABLE low for 10 cycles mid-dwell -> SEGMENT/BINARY frozen and no pulses; that digit's dwell lasts 14 cycles. RESET mid-frame with pending = 1 -> all outputs 0 the next cycle and no ACK afterwards.
6. With HEX_SCAN_BLANK_EN defined, display 0x00A0 -> BLANK = 1 at SEGMENT = 2, 3 and 0 at SEGMENT = 0, 1; display 0x0000 -> BLANK = 1 only at SEGMENT = 1..3.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Purpose : shared constants, types and helpers for the 4-digit hex display scanner.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package hex_display_pkg;

    localparam int NUM_DIGITS          = 4;
    localparam int DIGIT_W             = 4;
    localparam int IDX_W               = 2;
    localparam int DEFAULT_REFRESH_DIV = 100000;

    typedef logic [IDX_W-1:0]              digit_idx_t;
    typedef logic [NUM_DIGITS*DIGIT_W-1:0] disp_word_t;
    typedef logic [NUM_DIGITS-1:0]         dot_word_t;

    // One state per digit being driven; the encoding equals the digit index.
    typedef enum logic [IDX_W-1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_state_e;

    // True when digit idx and every higher digit of w are zero. Digit 0 is
    // never a leading zero so a value of 0 still shows a single "0".
    function automatic logic is_leading_zero(input disp_word_t w, input digit_idx_t idx);
        logic lz;
        unique case (idx)
            2'd1:    lz = (w[15:4]  == 12'h000);
            2'd2:    lz = (w[15:8]  == 8'h00);
            2'd3:    lz = (w[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// Purpose : prescaler producing one TICK every REFRESH_DIV enabled CLK cycles.
// Latency : TICK is combinational from the counter; it is high during the cycle the counter sits at REFRESH_DIV-1.
// Backpressure: ENABLE low holds the counter and forces TICK low.
// Ports: CLK, RESET (sync, active-high), ENABLE (count enable), TICK (one-cycle pulse).
module refresh_tick_gen
    import hex_display_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE,
    output logic TICK
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    // With REFRESH_DIV = 1 the counter is stuck at 0 and wrap is always true,
    // so every enabled cycle ticks.
    assign wrap = (cnt == LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (ENABLE) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    assign TICK = ENABLE && !RESET && wrap;

endmodule

// File: rtl/hex_display_scanner.sv
// Purpose : time-multiplexed scanner feeding BINARY/SEGMENT/DOT to the seven-segment decoder, with a frame-aligned load handshake.
// Latency : outputs update on the tick edge; a LOAD is committed on the next frame wrap (<= 4*REFRESH_DIV cycles), acknowledged by LOAD_ACK.
// Backpressure: ENABLE low freezes scan and outputs; LOAD is always accepted, a later LOAD before commit overwrites the earlier one.
// Ports: CLK, RESET (sync, active-high), VALUE_IN[15:0], DOTS_IN[3:0], LOAD, LOAD_ACK, ENABLE,
//        BINARY[3:0], SEGMENT[1:0], DOT, FRAME_DONE, and BLANK when HEX_SCAN_BLANK_EN is defined.
// Optional feature macro: HEX_SCAN_BLANK_EN (leading-zero blanking output).
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [15:0]            VALUE_IN,
    input  logic [NUM_DIGITS-1:0]  DOTS_IN,
    input  logic                   LOAD,
    output logic                   LOAD_ACK,
    input  logic                   ENABLE,
    output logic [DIGIT_W-1:0]     BINARY,
    output logic [IDX_W-1:0]       SEGMENT,
    output logic                   DOT,
`ifdef HEX_SCAN_BLANK_EN
    output logic                   BLANK,
`endif
    output logic                   FRAME_DONE
);

    logic        tick;
    scan_state_e state_q, state_d;
    digit_idx_t  next_idx;
    logic        at_last;
    logic        commit;
    logic        frame_done;

    disp_word_t  shadow_val, active_val, active_next_val;
    dot_word_t   shadow_dots, active_dots, active_next_dots;
    logic        pending;

    refresh_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .TICK   (tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= SCAN_D0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        at_last    = (state_q == SCAN_D3);
        frame_done = tick && at_last;
        commit     = tick && at_last && pending;
        if (tick) begin
            unique case (state_q)
                SCAN_D0: state_d = SCAN_D1;
                SCAN_D1: state_d = SCAN_D2;
                SCAN_D2: state_d = SCAN_D3;
                SCAN_D3: state_d = SCAN_D0;
                default: state_d = SCAN_D0;
            endcase
        end
    end

    assign next_idx = digit_idx_t'(state_d);

    // Bypass: on the commit edge digit 0 is fetched from the shadow copy so
    // the new value starts cleanly at the frame boundary.
    assign active_next_val  = commit ? shadow_val  : active_val;
    assign active_next_dots = commit ? shadow_dots : active_dots;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow_val  <= '0;
            shadow_dots <= '0;
            active_val  <= '0;
            active_dots <= '0;
            pending     <= 1'b0;
            BINARY      <= '0;
            SEGMENT     <= '0;
            DOT         <= 1'b0;
`ifdef HEX_SCAN_BLANK_EN
            BLANK       <= 1'b0;
`endif
        end else begin
            // A LOAD on the commit cycle wins over the clear: the fresh data
            // stays pending and commits one frame later.
            if (LOAD) begin
                shadow_val  <= VALUE_IN;
                shadow_dots <= DOTS_IN;
                pending     <= 1'b1;
            end else if (commit) begin
                pending     <= 1'b0;
            end

            if (commit) begin
                active_val  <= shadow_val;
                active_dots <= shadow_dots;
            end

            if (tick) begin
                SEGMENT <= next_idx;
                BINARY  <= active_next_val[next_idx*DIGIT_W +: DIGIT_W];
                DOT     <= active_next_dots[next_idx];
`ifdef HEX_SCAN_BLANK_EN
                BLANK   <= is_leading_zero(active_next_val, next_idx);
`endif
            end
        end
    end

    assign LOAD_ACK   = commit;
    assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Purpose : self-checking bench for hex_display_scanner with REFRESH_DIV = 4.
// Latency : inputs are driven and outputs sampled 2 time units after each rising edge.
// Backpressure: exercises ENABLE freeze, overwritten loads and a load on the commit cycle.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  dots_in;
    logic        load;
    logic        load_ack;
    logic        enable;
    logic [3:0]  binary;
    logic [1:0]  segment;
    logic        dot;
    logic        frame_done;
`ifdef HEX_SCAN_BLANK_EN
    logic        blank;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    hex_display_scanner #(
        .REFRESH_DIV (4)
    ) dut (
        .CLK        (clk),
        .RESET      (reset),
        .VALUE_IN   (value_in),
        .DOTS_IN    (dots_in),
        .LOAD       (load),
        .LOAD_ACK   (load_ack),
        .ENABLE     (enable),
        .BINARY     (binary),
        .SEGMENT    (segment),
        .DOT        (dot),
`ifdef HEX_SCAN_BLANK_EN
        .BLANK      (blank),
`endif
        .FRAME_DONE (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dots;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [3:0]  d3;
    } vec_t;

    vec_t vecs [4];

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance until the cycle in which FRAME_DONE is high (bounded).
    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        n_checks++;
        if (seen) begin
            n_pass++;
        end else begin
            $display("FAIL frame_done_timeout: got no FRAME_DONE expected one within 40 cycles");
        end
    endtask

    // Called at the first cycle of a frame; checks one whole frame and the
    // pulses on its final tick, and returns at the first cycle of the next frame.
    task automatic check_frame(input logic [3:0] n0, input logic [3:0] n1,
                               input logic [3:0] n2, input logic [3:0] n3,
                               input logic [3:0] dots, input logic exp_ack);
        logic [3:0] nib [4];
        nib = '{n0, n1, n2, n3};
        for (int d = 0; d < 4; d++) begin
            check("frame_segment", segment, d);
            check("frame_binary", binary, nib[d]);
            check("frame_dot", dot, dots[d]);
            repeat (3) cyc();
            if (d == 3) begin
                check("frame_end_frame_done", frame_done, 1);
                check("frame_end_load_ack", load_ack, exp_ack);
            end
            cyc();
        end
    endtask

`ifdef HEX_SCAN_BLANK_EN
    task automatic check_blank(input logic [3:0] exp_blank);
        for (int d = 0; d < 4; d++) begin
            check("blank_segment", segment, d);
            check("blank", blank, exp_blank[d]);
            repeat (4) cyc();
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         bad_ack;
        int         bad_bin;
        logic [3:0] prev_d3;

        vecs[0] = '{16'hA3C5, 4'b0100, 4'h5, 4'hC, 4'h3, 4'hA};
        vecs[1] = '{16'h1234, 4'b1001, 4'h4, 4'h3, 4'h2, 4'h1};
        vecs[2] = '{16'hFFFF, 4'b1111, 4'hF, 4'hF, 4'hF, 4'hF};
        vecs[3] = '{16'h0000, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0};

        reset    = 1'b1;
        enable   = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        dots_in  = 4'h0;
        cyc();
        cyc();
        check("reset_segment", segment, 0);
        check("reset_binary", binary, 0);
        check("reset_dot", dot, 0);
        check("reset_load_ack", load_ack, 0);
        check("reset_frame_done", frame_done, 0);
`ifdef HEX_SCAN_BLANK_EN
        check("reset_blank", blank, 0);
`endif
        reset = 1'b0;

        // Free-running scan: 4 cycles per digit, FRAME_DONE every 16th cycle.
        for (int i = 0; i < 32; i++) begin
            check("scan_segment", segment, (i / 4) % 4);
            check("scan_frame_done", frame_done, (i % 16) == 15);
            check("scan_load_ack", load_ack, 0);
            check("scan_binary", binary, 0);
            cyc();
        end

        // Table: load at digit 1, display unchanged until the wrap, then new value.
        prev_d3 = 4'h0;
        for (int v = 0; v < 4; v++) begin
            repeat (4) cyc();
            value_in = vecs[v].value;
            dots_in  = vecs[v].dots;
            load     = 1'b1;
            cyc();
            load = 1'b0;
            wait_fd();
            check("tbl_ack_with_frame_done", load_ack, 1);
            check("tbl_old_digit3_segment", segment, 3);
            check("tbl_old_digit3_binary", binary, prev_d3);
            cyc();
            check_frame(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].dots, 1'b0);
            prev_d3 = vecs[v].d3;
        end

        // Two loads in one frame: only the last one shows, one ACK.
        repeat (4) cyc();
        value_in = 16'h1111;
        dots_in  = 4'b0001;
        load     = 1'b1;
        cyc();
        value_in = 16'h2222;
        dots_in  = 4'b0010;
        cyc();
        load = 1'b0;
        check("dbl_no_early_change", binary, 0);
        wait_fd();
        check("dbl_single_ack", load_ack, 1);
        cyc();
        check_frame(4'h2, 4'h2, 4'h2, 4'h2, 4'b0010, 1'b0);

        // Load on the commit cycle: old shadow commits now, new one a frame later.
        repeat (4) cyc();
        value_in = 16'h1234;
        dots_in  = 4'b0000;
        load     = 1'b1;
        cyc();
        load = 1'b0;
        wait_fd();
        check("cc_first_ack", load_ack, 1);
        value_in = 16'h5678;
        dots_in  = 4'b1000;
        load     = 1'b1;
        cyc();
        load = 1'b0;
        check_frame(4'h4, 4'h3, 4'h2, 4'h1, 4'b0000, 1'b1);
        check_frame(4'h8, 4'h7, 4'h6, 4'h5, 4'b1000, 1'b0);

        // ENABLE low for 10 cycles mid-dwell stretches digit 1 to 14 cycles.
        repeat (4) cyc();
        repeat (2) cyc();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("frz_segment", segment, 1);
            check("frz_binary", binary, 4'h7);
            check("frz_frame_done", frame_done, 0);
            check("frz_load_ack", load_ack, 0);
            cyc();
        end
        enable = 1'b1;
        check("frz_resume_seg_a", segment, 1);
        cyc();
        check("frz_resume_seg_b", segment, 1);
        cyc();
        check("frz_next_segment", segment, 2);
        check("frz_next_binary", binary, 4'h6);

        // Reset with a load pending: outputs clear and the load is discarded.
        value_in = 16'hBEEF;
        dots_in  = 4'b1111;
        load     = 1'b1;
        cyc();
        load  = 1'b0;
        reset = 1'b1;
        cyc();
        check("rst_mid_segment", segment, 0);
        check("rst_mid_binary", binary, 0);
        check("rst_mid_dot", dot, 0);
        check("rst_mid_load_ack", load_ack, 0);
        check("rst_mid_frame_done", frame_done, 0);
        reset   = 1'b0;
        bad_ack = 0;
        bad_bin = 0;
        for (int i = 0; i < 24; i++) begin
            if (load_ack) bad_ack++;
            if (binary != 4'h0) bad_bin++;
            cyc();
        end
        check("rst_no_ack_after", bad_ack, 0);
        check("rst_value_discarded", bad_bin, 0);

`ifdef HEX_SCAN_BLANK_EN
        value_in = 16'h00A0;
        dots_in  = 4'b0000;
        load     = 1'b1;
        cyc();
        load = 1'b0;
        wait_fd();
        cyc();
        check_blank(4'b1100);
        repeat (4) cyc();
        value_in = 16'h0000;
        load     = 1'b1;
        cyc();
        load = 1'b0;
        wait_fd();
        cyc();
        check_blank(4'b1110);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
